// File: rtl/dmem_ctrl.sv
// Data memory for the MIPS memory stage: big-endian byte/half/word access, accept on req_ready, response WAIT_STATES+1 edges later.
// Requests are ignored while busy; DMEM_ALIGN_CHECK_EN makes misalignment an error (otherwise the address is force-aligned).
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 32,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q;
  logic [2:0]        cnt_q;
  logic              rd_q, wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] adr_q;
  logic [31:0]       wdata_q;
  logic              ready_q, valid_q, err_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              accept, enter_resp, mem_we;
  logic              cur_rd, cur_wr;
  logic [1:0]        cur_size, off, eff_off;
  logic [ADDR_W-1:0] cur_adr;
  logic [31:0]       cur_wdata;
  logic              oor, err_d;
  logic [IDX_W-1:0]  idx;
  logic [4:0]        shift;
  logic [31:0]       mask, wlane, word_rd, wr_word, rdata_d;

  assign accept     = ready_q & (req_read | req_write);
  assign enter_resp = ((state_q == S_IDLE) && accept && (WAIT_STATES == 0)) ||
                      ((state_q == S_WAIT) && (cnt_q == 3'd1));

  // With zero wait states the commit edge is the accept edge, so decode the live request.
  always_comb begin
    cur_rd    = rd_q;
    cur_wr    = wr_q;
    cur_size  = size_q;
    cur_adr   = adr_q;
    cur_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      cur_rd    = req_read;
      cur_wr    = req_write;
      cur_size  = req_size;
      cur_adr   = req_adr;
      cur_wdata = req_wdata;
    end
  end

  assign off = cur_adr[1:0];
  assign idx = cur_adr[IDX_W+1:2];
  assign oor = {2'b00, cur_adr[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS);

`ifdef DMEM_ALIGN_CHECK_EN
  logic misalign;
  assign misalign = ((cur_size == SZ_HALF) && off[0]) ||
                    ((cur_size == SZ_WORD) && (off != 2'b00));
  assign eff_off  = off;
  assign err_d    = oor | (cur_size == SZ_RSVD) | (cur_rd & cur_wr) | misalign;
`else
  assign eff_off  = (cur_size == SZ_HALF) ? {off[1], 1'b0} :
                    (cur_size == SZ_WORD) ? 2'b00 : off;
  assign err_d    = oor | (cur_size == SZ_RSVD) | (cur_rd & cur_wr);
`endif

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    shift = 5'd0;
    mask  = 32'hFFFF_FFFF;
    wlane = cur_wdata;
    case (cur_size)
      SZ_BYTE: begin
        shift = {~eff_off, 3'b000};
        mask  = 32'h0000_00FF << shift;
        wlane = {24'h0, cur_wdata[7:0]};
      end
      SZ_HALF: begin
        shift = eff_off[1] ? 5'd0 : 5'd16;
        mask  = 32'h0000_FFFF << shift;
        wlane = {16'h0, cur_wdata[15:0]};
      end
      default: ;
    endcase
  end

  assign word_rd = mem_q[idx];
  assign wr_word = (word_rd & ~mask) | ((wlane << shift) & mask);
  assign rdata_d = (cur_rd && !err_d) ? ((word_rd & mask) >> shift) : 32'h0;
  assign mem_we  = enter_resp & cur_wr & ~err_d;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      adr_q   <= '0;
      wdata_q <= 32'h0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            rd_q    <= req_read;
            wr_q    <= req_write;
            size_q  <= req_size;
            adr_q   <= req_adr;
            wdata_q <= req_wdata;
            ready_q <= 1'b0;
            if (WAIT_STATES == 0) begin
              state_q <= S_RESP;
              valid_q <= 1'b1;
              rdata_q <= rdata_d;
              err_q   <= err_d;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 3'(WAIT_STATES);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 3'd1) begin
            state_q <= S_RESP;
            valid_q <= 1'b1;
            rdata_q <= rdata_d;
            err_q   <= err_d;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Synthesisable, parametrised data memory for the MIPS memory stage.
- Generalises the behavioural RAM model to configurable depth, configurable wait states and a request/response handshake.
- Adds alignment and range error reporting.
- Accepts byte, halfword and word loads/stores with big-endian byte lanes; read data is returned right-justified and zero-extended.

Parameters:
- DEPTH_WORDS, 32, number of 32-bit words in the array; power of two, 4..4096.
- ADDR_W, 32, byte-address width.
- WAIT_STATES, 1, extra cycles between request accept and response; 0..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- req_read  in  1  load request.
- req_write  in  1  store request.
- req_size  in  2  access size: 0 = word, 1 = byte, 2 = halfword, 3 = reserved.
- req_adr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- req_ready  out  1  block can accept a request this cycle.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_rdata  out  32  load data, valid while rsp_valid = 1.
- rsp_err  out  1  error flag, valid while rsp_valid = 1.

Behaviour:
- Reset (rst = 0, asynchronous):
  - FSM goes to IDLE; req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Array contents are not cleared.
  - An access in flight when reset asserts is abandoned. A pending store that has not reached its commit cycle is never written.
- Accept: the request is captured on the edge where req_ready = 1 and (req_read | req_write) = 1. Address, size, data and op are registered at accept; inputs are don't-care afterwards.
- FSM:
  - IDLE: req_ready = 1. On accept, go to WAIT with cnt = WAIT_STATES, or straight to RESP if WAIT_STATES = 0.
  - WAIT: req_ready = 0; cnt decrements each cycle; go to RESP when cnt reaches 1.
  - RESP: req_ready = 0, rsp_valid = 1 for exactly one cycle; return to IDLE.
- Latency: accept on edge N gives rsp_valid high in cycle N+1+WAIT_STATES. Throughput is one access per WAIT_STATES+2 cycles.
- Store commit: the array is written on the edge that enters RESP. A load issued afterwards sees the new data.
- Address decode:
  - Word index = req_adr[ADDR_W-1:2]; byte offset = req_adr[1:0].
  - Index >= DEPTH_WORDS is out of range.
- Byte lanes are big-endian:
  - offset 0 maps to bits [31:24], offset 3 to bits [7:0].
  - Halfword at offset 0 maps to [31:16]; at offset 2 to [15:0].
- Store: byte writes req_wdata[7:0] to its lane; halfword writes req_wdata[15:0]; word writes all 32 bits. Other lanes are untouched.
- Load: byte returns {24'h0, lane}; halfword returns {16'h0, half}; word returns the full word.
- Errors. rsp_err = 1, no array write, rsp_rdata = 0, when any of:
  - the address is out of range;
  - req_size = 3;
  - req_read and req_write are both high;
  - a misaligned access occurs (see Optional Feature).
- An error response keeps the normal latency.
- Requests asserted while req_ready = 0 are ignored and not queued.

Optional Feature:
- DMEM_ALIGN_CHECK_EN defined:
  - halfword with req_adr[0] = 1 gives rsp_err = 1, no access;
  - word with req_adr[1:0] != 0 gives rsp_err = 1, no access.
- DMEM_ALIGN_CHECK_EN undefined:
  - the address is force-aligned (halfword clears bit 0; word clears bits [1:0]);
  - the access proceeds normally and rsp_err is never raised for alignment.

Test Plan:
- Reset mid-WAIT: WAIT_STATES = 3, store word 0xDEADBEEF to 0x10, assert rst = 0 one cycle after accept. Required: rsp_valid never pulses; after release, req_ready = 1 and a word load from 0x10 returns the old contents.
- Latency and lanes: WAIT_STATES = 1, store word 0x12345678 to 0x08.
  - The store's rsp_valid pulses 2 cycles after accept.
  - Byte loads at 0x08..0x0B return 0x12, 0x34, 0x56, 0x78.
  - Halfword loads at 0x08 and 0x0A return 0x1234 and 0x5678.
- Partial stores: after the above, store byte 0xAA to 0x09 and halfword 0xBEEF to 0x0A. Required: a word load at 0x08 returns 0x12AABEEF, rsp_err = 0.
- Range and illegal op:
  - word load at 0x80 (DEPTH_WORDS = 32) gives rsp_err = 1, rsp_rdata = 0;
  - req_read = req_write = 1 gives rsp_err = 1 and memory unchanged;
  - req_size = 3 gives rsp_err = 1.
- Alignment: word store 0xCAFEF00D to 0x06.
  - With DMEM_ALIGN_CHECK_EN: rsp_err = 1 and word 0x04 is unchanged.
  - Without it: word 0x04 reads 0xCAFEF00D, rsp_err = 0.
- Back-to-back with WAIT_STATES = 0: hold req_read high continuously.
  - Accepts occur every 2nd cycle; req_ready toggles 1, 0, 1, 0.
  - Exactly one rsp_valid pulse per accept, and no pulse for requests held while req_ready = 0.
